// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: internal pixel-clock enable, programmable timing and sync
// polarity, and a configurable delay that keeps sync/blanking aligned with a latent pixel source.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_LAT  = 1,
    parameter int unsigned RGB_W    = 12,
    parameter int unsigned CW       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [RGB_W-1:0] pix_data,
    output logic [CW-1:0]    pix_x,
    output logic [CW-1:0]    pix_y,
    output logic             pix_req,
    output logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);

    // One extra bit so region bounds equal to the total still fit.
    localparam logic [CW:0] H_ACT  = (CW + 1)'(H_ACTIVE);
    localparam logic [CW:0] HS_BEG = (CW + 1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END = (CW + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT  = (CW + 1)'(V_ACTIVE);
    localparam logic [CW:0] VS_BEG = (CW + 1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END = (CW + 1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CW-1:0]    h_q, h_d, v_q, v_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             run_q;
    logic             tick;
    logic             act, hs_act, vs_act;
    logic [2:0]       region, region_dly;
    logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    assign tick = en && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (!en) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        fcnt_d = fcnt_q;
        if (!en) begin
            h_d = '0;
            v_d = '0;
        end else if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d    = '0;
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            fcnt_q <= '0;
            run_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            fcnt_q <= fcnt_d;
            run_q  <= en;
        end
    end

    assign act    = ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
    assign hs_act = ({1'b0, h_q} >= HS_BEG) && ({1'b0, h_q} < HS_END);
    assign vs_act = ({1'b0, v_q} >= VS_BEG) && ({1'b0, v_q} < VS_END);
    assign region = {act, hs_act, vs_act};

    // Delay the region flags by the source latency so they meet the matching pixel data.
    if (PIX_LAT == 0) begin : g_no_pipe
        assign region_dly = region;
    end else begin : g_pipe
        logic [2:0] pipe_q [PIX_LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= '0;
            end else if (!en) begin
                for (int i = 0; i < PIX_LAT; i++) pipe_q[i] <= '0;
            end else if (tick) begin
                pipe_q[0] <= region;
                for (int i = 1; i < PIX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign region_dly = pipe_q[PIX_LAT-1];
    end

    always_comb begin
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        if (!en) begin
            de_d  = 1'b0;
            hs_d  = ~HS_POL;
            vs_d  = ~VS_POL;
            rgb_d = '0;
        end else if (tick) begin
            de_d  = region_dly[2];
            hs_d  = region_dly[1] ? HS_POL : ~HS_POL;
            vs_d  = region_dly[0] ? VS_POL : ~VS_POL;
            rgb_d = region_dly[2] ? pix_data : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            rgb_q <= '0;
        end else begin
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
        end
    end

    assign pix_x       = h_q;
    assign pix_y       = v_q;
    // Masked until the raster has been running for a clock, so reset/idle never requests.
    assign pix_req     = act && run_q;
    assign pix_tick    = tick;
    assign frame_start = tick && (h_q == '0) && (v_q == '0);
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_cnt   = fcnt_q;

    a_blank_rgb : assert property (@(posedge clk) disable iff (!rst_n) !de_q |-> (rgb_q == '0));
    a_tick_en   : assert property (@(posedge clk) disable iff (!rst_n) tick |-> en);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-timing instances (div 2 / lat 1, div 2 / lat 2 with
// positive hsync, div 1 / lat 0) checked every cycle against a tick-count raster model.
module tb_vga_timing_gen;

    localparam int HT = 14;
    localparam int VT = 8;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [2:0]           en;
    logic [2:0][11:0]     pd;
    logic [2:0][5:0]      px, py;
    logic [2:0]           preq, tick, hs, vs, de, fs;
    logic [2:0][11:0]     rgb;
    logic [2:0][7:0]      fc;

    int checks = 0;
    int errors = 0;

    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
        .PIX_LAT(1), .RGB_W(12), .CW(6)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .pix_data(pd[0]), .pix_x(px[0]), .pix_y(py[0]),
        .pix_req(preq[0]), .pix_tick(tick[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
        .rgb(rgb[0]), .frame_start(fs[0]), .frame_cnt(fc[0]));

    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0),
        .PIX_LAT(2), .RGB_W(12), .CW(6)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .pix_data(pd[1]), .pix_x(px[1]), .pix_y(py[1]),
        .pix_req(preq[1]), .pix_tick(tick[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
        .rgb(rgb[1]), .frame_start(fs[1]), .frame_cnt(fc[1]));

    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
        .PIX_LAT(0), .RGB_W(12), .CW(6)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .pix_data(pd[2]), .pix_x(px[2]), .pix_y(py[2]),
        .pix_req(preq[2]), .pix_tick(tick[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
        .rgb(rgb[2]), .frame_start(fs[2]), .frame_cnt(fc[2]));

    // Pixel sources: coordinate pattern delayed by the configured latency in pixel ticks.
    logic [11:0] s0 = '0, s1a = '0, s1b = '0;
    always @(posedge clk) begin
        if (tick[0]) s0 <= {py[0], px[0]};
        if (tick[1]) begin
            s1a <= {py[1], px[1]};
            s1b <= s1a;
        end
    end
    assign pd[0] = s0;
    assign pd[1] = s1b;
    assign pd[2] = {py[2], px[2]};

    function automatic int p_div(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic int p_lat(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int p_hpol(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int m_fc(input int b, input int cc, input int d);
        return (b + (cc / d) / FR) % 256;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, i, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s at %0t", name, $time);
    endtask

    // Model: c = clocks run since the raster (re)started, base = frame count at that point.
    int c [3];
    int base [3];
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                c[i]    <= 0;
                base[i] <= 0;
            end else if (en[i]) begin
                c[i] <= c[i] + 1;
            end else begin
                base[i] <= m_fc(base[i], c[i], p_div(i));
                c[i]    <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int d, n, h, v, q, hq, vq, e_hs, e_vs, e_de, e_rgb, e_tk;
            logic e_act;
            d    = p_div(i);
            n    = c[i] / d;
            h    = n % HT;
            v    = (n / HT) % VT;
            e_tk = (en[i] && (c[i] % d == d - 1)) ? 1 : 0;
            q    = n - (p_lat(i) + 1);
            e_de = 0;
            e_hs = 1 - p_hpol(i);
            e_vs = 1;
            e_rgb = 0;
            if (q >= 0) begin
                hq    = q % HT;
                vq    = (q / HT) % VT;
                e_act = (hq < 8) && (vq < 4);
                e_de  = e_act ? 1 : 0;
                if (hq >= 10 && hq < 13) e_hs = p_hpol(i);
                if (vq >= 5 && vq < 7) e_vs = 0;
                e_rgb = e_act ? ((vq << 6) | hq) : 0;
            end
            chk("pix_x", i, 32'(px[i]), h);
            chk("pix_y", i, 32'(py[i]), v);
            chk("pix_req", i, 32'(preq[i]), ((c[i] > 0) && h < 8 && v < 4) ? 1 : 0);
            chk("pix_tick", i, 32'(tick[i]), e_tk);
            chk("frame_start", i, 32'(fs[i]), (e_tk == 1 && h == 0 && v == 0) ? 1 : 0);
            chk("frame_cnt", i, 32'(fc[i]), m_fc(base[i], c[i], d));
            chk("hsync", i, 32'(hs[i]), e_hs);
            chk("vsync", i, 32'(vs[i]), e_vs);
            chk("de", i, 32'(de[i]), e_de);
            chk("rgb", i, 32'(rgb[i]), e_rgb);
        end
    end

    function automatic logic sel(input int s);
        case (s)
            0:       return hs[0];
            1:       return vs[0];
            2:       return de[0];
            3:       return fs[0];
            4:       return hs[2];
            default: return de[1];
        endcase
    endfunction

    // Returns the number of clocks until sel(s) moves to level lvl; -1 on timeout.
    task automatic wait_edge(input int s, input logic lvl, input int bound, output int n);
        logic prev, cur;
        prev = sel(s);
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            #1;
            cur = sel(s);
            if (cur == lvl && prev != lvl) begin
                n = k;
                return;
            end
            prev = cur;
        end
        n = -1;
        timeout($sformatf("edge sel %0d", s));
    endtask

    task automatic count_lvl(input int s, input logic lvl, input int len, output int k);
        k = 0;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            #1;
            if (sel(s) == lvl) k++;
        end
    endtask

    initial begin
        int n, k;
        bit found;
        rst_n = 1'b0;
        en    = 3'b000;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        en = 3'b111;
        repeat (40) @(negedge clk);

        // Reset mid-frame: outputs return to reset values without waiting for a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hsync", 0, 32'(hs[0]), 1);
        chk("rst_hsync_pos", 1, 32'(hs[1]), 0);
        chk("rst_vsync", 0, 32'(vs[0]), 1);
        chk("rst_de", 0, 32'(de[0]), 0);
        chk("rst_rgb", 0, 32'(rgb[0]), 0);
        chk("rst_pix_x", 0, 32'(px[0]), 0);
        chk("rst_pix_req", 0, 32'(preq[0]), 0);
        chk("rst_frame_cnt", 0, 32'(fc[0]), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("first_cycle_tick", 0, 32'(tick[0]), 0);
        @(posedge clk);
        #1;
        chk("first_tick", 0, 32'(tick[0]), 1);
        chk("first_frame_start", 0, 32'(fs[0]), 1);

        // Latency-2 alignment: first visible output is (0,0), then x advances per tick.
        wait_edge(5, 1'b1, 20, n);
        chk("align_first_rgb", 1, 32'(rgb[1]), 32'h000);
        @(posedge clk);
        @(posedge clk);
        #1 chk("align_next_rgb", 1, 32'(rgb[1]), 32'h001);
        @(posedge clk);
        @(posedge clk);
        #1 chk("align_next2_rgb", 1, 32'(rgb[1]), 32'h002);

        for (int f = 0; f < 3; f++) wait_edge(3, 1'b1, 300, n);
        chk("frame_period", 0, n, 224);
        chk("frame_cnt_3", 0, 32'(fc[0]), 3);

        wait_edge(0, 1'b0, 100, n);
        wait_edge(0, 1'b0, 100, n);
        chk("hs_period", 0, n, 28);
        count_lvl(0, 1'b0, 28, k);
        chk("hs_low_clks", 0, k, 6);
        wait_edge(2, 1'b1, 300, n);
        wait_edge(0, 1'b0, 100, n);
        chk("de_to_hs_fall", 0, n, 20);
        wait_edge(2, 1'b1, 300, n);
        count_lvl(2, 1'b1, 27, k);
        chk("de_width_after_rise", 0, k, 15);
        count_lvl(1, 1'b0, 224, k);
        chk("vs_low_clks", 0, k, 56);
        count_lvl(3, 1'b1, 224, k);
        chk("fs_per_frame", 0, k, 1);

        // Drop en at (5,2) and restart.
        found = 1'b0;
        for (int j = 0; j < 300 && !found; j++) begin
            @(negedge clk);
            #1;
            if (px[0] == 6'd5 && py[0] == 6'd2) found = 1'b1;
        end
        if (!found) timeout("reach h5 v2");
        #1 en[0] = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_hsync", 0, 32'(hs[0]), 1);
        chk("idle_vsync", 0, 32'(vs[0]), 1);
        chk("idle_de", 0, 32'(de[0]), 0);
        chk("idle_rgb", 0, 32'(rgb[0]), 0);
        chk("idle_pix_x", 0, 32'(px[0]), 0);
        chk("idle_pix_y", 0, 32'(py[0]), 0);
        repeat (3) @(negedge clk);
        #2 en[0] = 1'b1;
        #1 chk("restart_no_fs", 0, 32'(fs[0]), 0);
        @(posedge clk);
        #1 chk("restart_fs", 0, 32'(fs[0]), 1);

        // Divide-by-1 instance.
        k = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            #1;
            if (tick[2]) k++;
        end
        chk("div1_ticks", 2, k, 50);
        wait_edge(4, 1'b0, 50, n);
        wait_edge(4, 1'b0, 50, n);
        chk("div1_line_period", 2, n, 14);

        found = 1'b0;
        for (int j = 0; j < 30000 && !found; j++) begin
            @(negedge clk);
            #1;
            if (fc[2] == 8'd255) found = 1'b1;
        end
        if (!found) timeout("frame_cnt 255");
        found = 1'b0;
        for (int j = 0; j < 200 && !found; j++) begin
            @(negedge clk);
            #1;
            if (fc[2] != 8'd255) found = 1'b1;
        end
        if (!found) timeout("frame_cnt wrap");
        chk("frame_cnt_wrap", 2, 32'(fc[2]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
